neuron_activation: RTL and testbench

- Downstream stage of the dot-product unit in the MLP datapath.
- Accepts one IEEE-754 single-precision dot-product result plus a per-neuron bias, computes z = dot + bias, applies ReLU and presents the neuron activation to the next layer's vector buffer.
- Uses valid/ready handshakes on both sides and processes one neuron at a time.

---
 rtl/neuron_activation.sv | 188 ++++++++++++++++++
 tb/tb_neuron_activation.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/neuron_activation.sv
// neuron_activation: float32 z = dot + bias, then ReLU, one neuron at a time
//
// Ports:
//   CLK, reset            clock and synchronous active-high reset
//   in_valid/in_ready     input handshake for dot_in and bias_in (float32)
//   out_valid/out_ready   output handshake for act_out (float32) and out_flags
//   out_flags             [1] overflow to +-Inf from finite operands, [0] clamped (z < 0)
//
// Parameters:
//   BIAS_EN      0 bypasses the bias add (bias treated as +0), latency unchanged
//   LEAKY_SHIFT  negative slope 2^-LEAKY_SHIFT, only used with LEAKY_RELU_EN
//
// Optional feature: define LEAKY_RELU_EN for leaky ReLU instead of plain ReLU.
module neuron_activation #(
    parameter int unsigned BIAS_EN     = 1,
    parameter int unsigned LEAKY_SHIFT = 3
) (
    input  logic        CLK,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] dot_in,
    input  logic [31:0] bias_in,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] act_out,
    output logic [1:0]  out_flags
);

    if (LEAKY_SHIFT < 1 || LEAKY_SHIFT > 31) begin : g_bad_leaky_shift
        $error("LEAKY_SHIFT must be in 1..31");
    end

    typedef enum logic [2:0] {IDLE, ALIGN, ADD, NORM, ACT, OUT} state_t;

    state_t      state_q;
    logic [31:0] a_q, b_q, z_q, act_q;
    logic        sl_q, ss_q, ovf_q, in_ready_q, out_valid_q;
    logic [7:0]  exp_q;
    logic [26:0] ml_q, ms_q;
    logic [27:0] sum_q;
    logic [1:0]  flags_q;

    logic [7:0]  ea, eb, shift;
    logic [23:0] ma, mb;
    logic        a_big;
    logic [26:0] ms_ext, lost;
    logic        sl_d, ss_d;
    logic [7:0]  exp_d;
    logic [26:0] ml_d, ms_d;
    logic [27:0] sum_d;
    logic [4:0]  lz;
    logic signed [9:0] e_n;
    logic [22:0] mant_n;
    logic        a_nan, b_nan, a_inf, b_inf, nan_any;
    logic [31:0] z_d, act_d;
    logic        ovf_d, z_nan, neg;
    logic [1:0]  flags_d;
`ifdef LEAKY_RELU_EN
    logic signed [9:0] le;
`endif

    // Align: subnormals have mantissa 0 (flushed), larger magnitude goes first.
    // The smaller mantissa carries guard/round/sticky bits below its LSB.
    always_comb begin
        ea     = a_q[30:23];
        eb     = b_q[30:23];
        ma     = (ea == 8'd0) ? 24'd0 : {1'b1, a_q[22:0]};
        mb     = (eb == 8'd0) ? 24'd0 : {1'b1, b_q[22:0]};
        a_big  = {ea, ma} >= {eb, mb};
        sl_d   = a_big ? a_q[31] : b_q[31];
        ss_d   = a_big ? b_q[31] : a_q[31];
        exp_d  = a_big ? ea : eb;
        ml_d   = {(a_big ? ma : mb), 3'b000};
        ms_ext = {(a_big ? mb : ma), 3'b000};
        shift  = exp_d - (a_big ? eb : ea);
        lost   = ms_ext & ~({27{1'b1}} << shift);
        ms_d   = (shift >= 8'd27) ? {26'd0, |ms_ext} : (ms_ext >> shift) | {26'd0, |lost};
    end

    // Add: magnitudes are ordered, so subtraction never goes negative.
    always_comb begin
        sum_d = (sl_q ^ ss_q) ? ({1'b0, ml_q} - {1'b0, ms_q}) : ({1'b0, ml_q} + {1'b0, ms_q});
    end

    // Normalize with truncation; specials are decided from the captured operands.
    always_comb begin
        lz = 5'd0;
        for (int i = 0; i < 27; i++)
            if (sum_q[i]) lz = 5'(26 - i);
        e_n     = sum_q[27] ? $signed({2'b00, exp_q}) + 10'sd1
                            : $signed({2'b00, exp_q}) - $signed({5'd0, lz});
        mant_n  = sum_q[27] ? sum_q[26:4] : 23'((sum_q[26:0] << lz) >> 3);
        a_nan   = (&a_q[30:23]) && (|a_q[22:0]);
        b_nan   = (&b_q[30:23]) && (|b_q[22:0]);
        a_inf   = (&a_q[30:23]) && !(|a_q[22:0]);
        b_inf   = (&b_q[30:23]) && !(|b_q[22:0]);
        nan_any = a_nan || b_nan || (a_inf && b_inf && (a_q[31] ^ b_q[31]));
        z_d     = nan_any              ? 32'h7FC0_0000 :
                  a_inf                ? a_q :
                  b_inf                ? b_q :
                  (sum_q == 28'd0)     ? 32'd0 :
                  (e_n >= 10'sd255)    ? {sl_q, 8'hFF, 23'd0} :
                  (e_n <= 10'sd0)      ? {sl_q, 31'd0} :
                                         {sl_q, e_n[7:0], mant_n};
        ovf_d   = !nan_any && !a_inf && !b_inf && (sum_q != 28'd0) && (e_n >= 10'sd255);
    end

    // Activation: -0 and NaN are never treated as negative.
    always_comb begin
        z_nan   = (&z_q[30:23]) && (|z_q[22:0]);
        neg     = z_q[31] && !z_nan && (z_q != 32'h8000_0000);
`ifdef LEAKY_RELU_EN
        le      = $signed({2'b00, z_q[30:23]}) - $signed(10'(LEAKY_SHIFT));
        act_d   = !neg                     ? ((z_q == 32'h8000_0000) ? 32'd0 : z_q) :
                  (&z_q[30:23])            ? z_q :
                  (le <= 10'sd0)           ? 32'h8000_0000 :
                                             {1'b1, le[7:0], z_q[22:0]};
`else
        act_d   = (neg || z_q == 32'h8000_0000) ? 32'd0 : z_q;
`endif
        flags_d = {ovf_q, neg};
    end

    always_ff @(posedge CLK) begin
        if (reset) begin
            state_q     <= IDLE;
            a_q         <= '0;
            b_q         <= '0;
            sl_q        <= 1'b0;
            ss_q        <= 1'b0;
            exp_q       <= '0;
            ml_q        <= '0;
            ms_q        <= '0;
            sum_q       <= '0;
            z_q         <= '0;
            ovf_q       <= 1'b0;
            act_q       <= '0;
            flags_q     <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (in_valid && in_ready_q) begin
                    a_q        <= dot_in;
                    b_q        <= (BIAS_EN != 0) ? bias_in : 32'd0;
                    in_ready_q <= 1'b0;
                    state_q    <= ALIGN;
                end
                ALIGN: begin
                    sl_q    <= sl_d;
                    ss_q    <= ss_d;
                    exp_q   <= exp_d;
                    ml_q    <= ml_d;
                    ms_q    <= ms_d;
                    state_q <= ADD;
                end
                ADD: begin
                    sum_q   <= sum_d;
                    state_q <= NORM;
                end
                NORM: begin
                    z_q     <= z_d;
                    ovf_q   <= ovf_d;
                    state_q <= ACT;
                end
                ACT: begin
                    act_q       <= act_d;
                    flags_q     <= flags_d;
                    out_valid_q <= 1'b1;
                    state_q     <= OUT;
                end
                OUT: if (out_ready) begin
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                    state_q     <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign act_out   = act_q;
    assign out_flags = flags_q;

endmodule

// File: tb/tb_neuron_activation.sv
// tb_neuron_activation: randomized check of neuron_activation against an exact-arithmetic model
//
// Two instances share all inputs: u_dut with the bias add, u_nb with BIAS_EN=0.
module tb_neuron_activation;

    logic        CLK = 1'b0;
    logic        reset, in_valid, out_ready;
    logic [31:0] dot_in, bias_in;
    logic        in_ready, out_valid, nb_in_ready, nb_out_valid;
    logic [31:0] act_out, nb_act_out;
    logic [1:0]  out_flags, nb_out_flags;
    logic [31:0] last_act, last_nb_act;
    logic [1:0]  last_flags;
    int          checks = 0;
    int          errors = 0;

    always #5 CLK = ~CLK;

    neuron_activation #(.BIAS_EN(1), .LEAKY_SHIFT(3)) u_dut (
        .CLK(CLK), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .dot_in(dot_in), .bias_in(bias_in), .out_valid(out_valid), .out_ready(out_ready),
        .act_out(act_out), .out_flags(out_flags)
    );

    neuron_activation #(.BIAS_EN(0), .LEAKY_SHIFT(3)) u_nb (
        .CLK(CLK), .reset(reset), .in_valid(in_valid), .in_ready(nb_in_ready),
        .dot_in(dot_in), .bias_in(bias_in), .out_valid(nb_out_valid), .out_ready(out_ready),
        .act_out(nb_act_out), .out_flags(nb_out_flags)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    // Exact sum on a 300-bit fixed-point grid (value = V * 2^-149), then truncate.
    function automatic logic [33:0] model(input logic [31:0] a, input logic [31:0] b);
        logic [299:0] va, vb, s;
        logic [31:0]  z, act;
        logic         ovf, cl, sg, an, bn, ai, bi;
        int           p, e;
        an  = (a[30:23] == 8'hFF) && (a[22:0] != 0);
        bn  = (b[30:23] == 8'hFF) && (b[22:0] != 0);
        ai  = (a[30:23] == 8'hFF) && (a[22:0] == 0);
        bi  = (b[30:23] == 8'hFF) && (b[22:0] == 0);
        ovf = 1'b0;
        sg  = 1'b0;
        if (an || bn || (ai && bi && a[31] != b[31])) z = 32'h7FC0_0000;
        else if (ai) z = a;
        else if (bi) z = b;
        else begin
            va = (a[30:23] == 0) ? '0 : (300'({1'b1, a[22:0]}) << (int'(a[30:23]) - 1));
            vb = (b[30:23] == 0) ? '0 : (300'({1'b1, b[22:0]}) << (int'(b[30:23]) - 1));
            if (a[31] == b[31]) begin s = va + vb; sg = a[31]; end
            else if (va >= vb) begin s = va - vb; sg = a[31]; end
            else begin s = vb - va; sg = b[31]; end
            if (s == 0) z = 32'd0;
            else begin
                p = 0;
                for (int i = 0; i < 300; i++) if (s[i]) p = i;
                e = p - 22;
                if (e >= 255) begin z = {sg, 8'hFF, 23'd0}; ovf = 1'b1; end
                else if (e <= 0) z = {sg, 31'd0};
                else begin s = s >> (p - 23); z = {sg, 8'(e), s[22:0]}; end
            end
        end
        cl  = 1'b0;
        act = z;
        if (z[30:23] == 8'hFF && z[22:0] != 0) act = z;
        else if (z == 32'h8000_0000) act = 32'd0;
        else if (z[31]) begin
            cl = 1'b1;
`ifdef LEAKY_RELU_EN
            if (z[30:23] == 8'hFF) act = z;
            else if (int'(z[30:23]) - 3 <= 0) act = 32'h8000_0000;
            else act = {1'b1, 8'(int'(z[30:23]) - 3), z[22:0]};
`else
            act = 32'd0;
`endif
        end
        return {ovf, cl, act};
    endfunction

    function automatic logic [31:0] rand_fp();
        logic [31:0] sp [8] = '{32'h0, 32'h8000_0000, 32'h7F80_0000, 32'hFF80_0000,
                                32'h7FC0_0000, 32'h7F80_0001, 32'h0000_0123, 32'h7F7F_FFFF};
        int k;
        k = $urandom_range(0, 9);
        if (k == 0) return sp[$urandom_range(0, 7)];
        if (k <= 3) return $urandom;
        if (k == 4) return {1'($urandom), 8'($urandom_range(250, 254)), 23'($urandom)};
        if (k == 5) return {1'($urandom), 8'($urandom_range(1, 4)), 23'($urandom)};
        return {1'($urandom), 8'($urandom_range(120, 135)), 23'($urandom)};
    endfunction

    // Called at a negedge with the block idle; returns at a negedge with it idle again.
    task automatic run_op(input logic [31:0] d, input logic [31:0] b, input int hold);
        logic [33:0] e1, e0;
        int lat;
        e1 = model(d, b);
        e0 = model(d, 32'd0);
        check("idle_ready", 64'(in_ready), 64'd1);
        dot_in = d; bias_in = b; in_valid = 1'b1; out_ready = (hold == 0);
        @(posedge CLK);
        @(negedge CLK);
        in_valid = 1'b0; dot_in = $urandom; bias_in = $urandom;
        lat = 0;
        while (!out_valid && lat < 12) begin
            @(negedge CLK);
            lat++;
        end
        check("latency", 64'(lat), 64'd4);
        check("nb_valid", 64'(nb_out_valid), 64'd1);
        check($sformatf("act %h+%h", d, b), 64'(act_out), 64'(e1[31:0]));
        check($sformatf("flags %h+%h", d, b), 64'(out_flags), 64'(e1[33:32]));
        check($sformatf("nb_act %h", d), 64'(nb_act_out), 64'(e0[31:0]));
        check($sformatf("nb_flags %h", d), 64'(nb_out_flags), 64'(e0[33:32]));
        last_act = act_out; last_flags = out_flags; last_nb_act = nb_act_out;
        for (int i = 0; i < hold; i++) begin
            in_valid = 1'b1; dot_in = $urandom; bias_in = $urandom;
            @(negedge CLK);
            check("hold_valid", 64'(out_valid), 64'd1);
            check("hold_act", 64'(act_out), 64'(e1[31:0]));
            check("hold_flags", 64'(out_flags), 64'(e1[33:32]));
            check("hold_ready", 64'(in_ready), 64'd0);
        end
        in_valid = 1'b0; out_ready = 1'b1;
        @(negedge CLK);
        check("done_valid", 64'(out_valid), 64'd0);
        check("done_ready", 64'(in_ready), 64'd1);
    endtask

    initial begin
        logic [31:0] d, b;
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; dot_in = '0; bias_in = '0;
        repeat (2) @(negedge CLK);
        check("rst_ready", 64'(in_ready), 64'd1);
        check("rst_valid", 64'(out_valid), 64'd0);
        check("rst_act", 64'(act_out), 64'd0);
        check("rst_flags", 64'(out_flags), 64'd0);
        reset = 1'b0;
        @(negedge CLK);

        run_op(32'h3F80_0000, 32'h3F00_0000, 0);
        check("tp_sum", 64'(last_act), 64'h3FC0_0000);
        check("tp_sum_flags", 64'(last_flags), 64'd0);
        run_op(32'hC000_0000, 32'h3F00_0000, 0);
`ifdef LEAKY_RELU_EN
        check("tp_neg", 64'(last_act), 64'hBE40_0000);
`else
        check("tp_neg", 64'(last_act), 64'h0);
`endif
        check("tp_neg_flags", 64'(last_flags), 64'd1);
        run_op(32'h7F7F_FFFF, 32'h7F7F_FFFF, 0);
        check("tp_ovf", 64'(last_act), 64'h7F80_0000);
        check("tp_ovf_flags", 64'(last_flags), 64'd2);
        run_op(32'h4040_0000, 32'hC040_0000, 5);
        check("tp_cancel", 64'(last_act), 64'h0);
        check("tp_cancel_flags", 64'(last_flags), 64'd0);
        run_op(32'h40A0_0000, 32'hC120_0000, 0);
        check("tp_nobias", 64'(last_nb_act), 64'h40A0_0000);
        run_op(32'h7FC0_0001, 32'h3F80_0000, 0);
        check("tp_nan", 64'(last_act), 64'h7FC0_0000);
        run_op(32'h7F80_0000, 32'hFF80_0000, 0);
        run_op(32'hFF80_0000, 32'h3F80_0000, 0);
        run_op(32'h0080_0001, 32'h8080_0000, 0);
        run_op(32'h0000_0123, 32'h8000_0000, 2);
        run_op(32'h4B80_0000, 32'hB380_0001, 0);

        // Reset while the neuron is in ADD discards it.
        dot_in = 32'h3F80_0000; bias_in = 32'h3F00_0000; in_valid = 1'b1; out_ready = 1'b1;
        @(posedge CLK);
        @(negedge CLK);
        in_valid = 1'b0;
        @(negedge CLK);
        reset = 1'b1;
        @(negedge CLK);
        check("midrst_valid", 64'(out_valid), 64'd0);
        check("midrst_act", 64'(act_out), 64'd0);
        check("midrst_ready", 64'(in_ready), 64'd1);
        reset = 1'b0;
        repeat (5) begin
            @(negedge CLK);
            check("midrst_quiet", 64'(out_valid), 64'd0);
        end
        run_op(32'h3F80_0000, 32'h3F00_0000, 0);
        check("midrst_after", 64'(last_act), 64'h3FC0_0000);

        for (int n = 0; n < 200; n++) begin
            d = rand_fp();
            b = ($urandom_range(0, 4) == 0) ? ({~d[31], d[30:0]} ^ 32'($urandom_range(0, 7))) : rand_fp();
            run_op(d, b, ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 3)) : 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
